// File: rtl/usb4_pcs_pkg.sv
// Shared constants and types for the USB4 receive PCS block path.
// Block layout: 2-bit sync header followed by a 64-bit payload.
package usb4_pcs_pkg;
  localparam int BLOCK_W   = 66;
  localparam int PAYLOAD_W = 64;
  localparam logic [1:0] HDR_DATA = 2'b10;
  localparam logic [1:0] HDR_CTRL = 2'b01;

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} align_state_t;

  function automatic logic hdr_valid(input logic [1:0] hdr);
    return (hdr == HDR_DATA) || (hdr == HDR_CTRL);
  endfunction
endpackage

// File: rtl/usb4_block_collector.sv
// Assembles 66-bit blocks from the serial stream; supports a one-bit slip
// by discarding the next accepted bit after a slip request.
module usb4_block_collector
  import usb4_pcs_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               bit_in,
  input  logic               bit_valid,
  input  logic               clear,
  input  logic               slip,
  output logic               blk_done,
  output logic [BLOCK_W-1:0] blk
);
  logic [BLOCK_W-1:0] shift_reg;
  logic [6:0]         bit_cnt_reg;
  logic               discard_reg;
  logic               accept;

  assign accept   = bit_valid && !clear && !discard_reg;
  assign blk_done = accept && (bit_cnt_reg == 7'(BLOCK_W - 1));
  // Right shift: the first accepted bit of a block ends up in blk[0].
  assign blk      = {bit_in, shift_reg[BLOCK_W-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      discard_reg <= 1'b0;
    end else if (clear) begin
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      discard_reg <= 1'b0;
    end else if (bit_valid) begin
      if (discard_reg) begin
        discard_reg <= 1'b0;
      end else begin
        shift_reg   <= blk;
        bit_cnt_reg <= blk_done ? 7'd0 : bit_cnt_reg + 7'd1;
      end
      if (slip) discard_reg <= 1'b1;
    end
  end
endmodule

// File: rtl/usb4_block_aligner.sv
// Block lock acquisition/maintenance over the descrambled bit stream;
// emits locked payload words tagged data/control.
module usb4_block_aligner
  import usb4_pcs_pkg::*;
#(
  parameter int LOCK_CNT  = 64,
  parameter int WINDOW    = 64,
  parameter int BAD_LIMIT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  input  logic                 lane_rst,
  output logic [PAYLOAD_W-1:0] block_data,
  output logic                 block_is_ctrl,
  output logic                 block_valid,
  output logic                 block_lock,
  output logic                 slip_pulse
);
  logic               blk_done;
  logic [BLOCK_W-1:0] blk;
  logic [1:0]         hdr;
  logic               hdr_ok;

  align_state_t state_reg, state_next;
  logic [7:0]   good_cnt_reg, good_cnt_next;
  logic [7:0]   win_cnt_reg, win_cnt_next;
  logic [7:0]   bad_cnt_reg, bad_cnt_next;
  logic         slip_take, emit;

  logic [PAYLOAD_W-1:0] block_data_reg;
  logic                 block_is_ctrl_reg, block_valid_reg, slip_pulse_reg;

  usb4_block_collector u_collector (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .clear     (lane_rst),
    .slip      (slip_take),
    .blk_done  (blk_done),
    .blk       (blk)
  );

  assign hdr    = blk[1:0];
  assign hdr_ok = hdr_valid(hdr);

  always_comb begin
    state_next    = state_reg;
    good_cnt_next = good_cnt_reg;
    win_cnt_next  = win_cnt_reg;
    bad_cnt_next  = bad_cnt_reg;
    slip_take     = 1'b0;
    if (blk_done) begin
      case (state_reg)
        SEARCH: begin
          if (hdr_ok) begin
            state_next    = VERIFY;
            good_cnt_next = 8'd1;
          end else begin
            slip_take = 1'b1;
          end
        end
        VERIFY: begin
          if (hdr_ok) begin
            good_cnt_next = good_cnt_reg + 8'd1;
            if (good_cnt_next == 8'(LOCK_CNT)) begin
              state_next   = LOCKED;
              win_cnt_next = 8'd0;
              bad_cnt_next = 8'd0;
            end
          end else begin
            state_next    = SEARCH;
            good_cnt_next = 8'd0;
            slip_take     = 1'b1;
          end
        end
        LOCKED: begin
          win_cnt_next = win_cnt_reg + 8'd1;
          bad_cnt_next = bad_cnt_reg + {7'd0, !hdr_ok};
          // Loss of lock wins over a window closing on the same block.
          if (bad_cnt_next == 8'(BAD_LIMIT)) begin
            state_next    = SEARCH;
            good_cnt_next = 8'd0;
            win_cnt_next  = 8'd0;
            bad_cnt_next  = 8'd0;
            slip_take     = 1'b1;
          end else if (win_cnt_next == 8'(WINDOW)) begin
            win_cnt_next = 8'd0;
            bad_cnt_next = 8'd0;
          end
        end
        default: state_next = SEARCH;
      endcase
    end
  end

  assign emit = blk_done && hdr_ok && (state_next == LOCKED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg         <= SEARCH;
      good_cnt_reg      <= '0;
      win_cnt_reg       <= '0;
      bad_cnt_reg       <= '0;
      block_data_reg    <= '0;
      block_is_ctrl_reg <= 1'b0;
      block_valid_reg   <= 1'b0;
      slip_pulse_reg    <= 1'b0;
    end else if (lane_rst) begin
      // Realign keeps the last payload word on the bus.
      state_reg         <= SEARCH;
      good_cnt_reg      <= '0;
      win_cnt_reg       <= '0;
      bad_cnt_reg       <= '0;
      block_is_ctrl_reg <= 1'b0;
      block_valid_reg   <= 1'b0;
      slip_pulse_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      good_cnt_reg    <= good_cnt_next;
      win_cnt_reg     <= win_cnt_next;
      bad_cnt_reg     <= bad_cnt_next;
      block_valid_reg <= emit;
      slip_pulse_reg  <= slip_take;
      if (emit) begin
        block_data_reg    <= blk[BLOCK_W-1:2];
        block_is_ctrl_reg <= (hdr == HDR_CTRL);
      end
    end
  end

  assign block_data    = block_data_reg;
  assign block_is_ctrl = block_is_ctrl_reg;
  assign block_valid   = block_valid_reg;
  assign slip_pulse    = slip_pulse_reg;
  assign block_lock    = (state_reg == LOCKED);
endmodule

// File: tb/tb_usb4_block_aligner.sv
// Randomized bench for usb4_block_aligner against a queue-based block model;
// DUT and model event logs (emitted blocks, slips, lock changes) are compared.
module tb_usb4_block_aligner;
  localparam int LOCK_CNT  = 4;
  localparam int WINDOW    = 8;
  localparam int BAD_LIMIT = 2;
  localparam logic [63:0] PAT  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] CPAT = 64'hFFFF_0000_FFFF_0000;
  localparam int M_SEARCH = 0, M_VERIFY = 1, M_LOCKED = 2;

  logic clk = 1'b0, rst = 1'b1, bit_in = 1'b0, bit_valid = 1'b0, lane_rst = 1'b0;
  logic [63:0] block_data;
  logic block_is_ctrl, block_valid, block_lock, slip_pulse;

  usb4_block_aligner #(.LOCK_CNT(LOCK_CNT), .WINDOW(WINDOW), .BAD_LIMIT(BAD_LIMIT)) dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .lane_rst(lane_rst),
    .block_data(block_data), .block_is_ctrl(block_is_ctrl), .block_valid(block_valid),
    .block_lock(block_lock), .slip_pulse(slip_pulse)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0;
  string dut_ev[$], mdl_ev[$];
  int dut_nvalid = 0, dut_nslip = 0, lock_rise_cyc = -1;
  logic dut_lock_prev = 1'b0;
  logic [63:0] dut_last_data = '0;
  logic dut_last_ctrl = 1'b0;

  // Reference model state
  int m_st = M_SEARCH, m_good = 0, m_win = 0, m_bad = 0;
  bit m_q[$];
  bit m_skip = 1'b0, m_lock = 1'b0;
  logic [63:0] m_last_data = '0;

  task automatic model_clear();
    m_st = M_SEARCH; m_good = 0; m_win = 0; m_bad = 0;
    m_q.delete(); m_skip = 1'b0;
  endtask

  task automatic model_edge(input bit b, input bit v, input bit lr, input int stamp);
    bit lock_before = m_lock;
    if (lr) begin
      model_clear();
    end else if (v) begin
      if (m_skip) m_skip = 1'b0;
      else begin
        m_q.push_back(b);
        if (m_q.size() == 66) begin
          bit [1:0] h;
          bit ok, slip;
          logic [63:0] d;
          h = {m_q[1], m_q[0]};
          ok = (h == 2'b10) || (h == 2'b01);
          for (int i = 0; i < 64; i++) d[i] = m_q[i+2];
          m_q.delete();
          slip = 1'b0;
          if (m_st == M_SEARCH) begin
            if (ok) begin m_st = M_VERIFY; m_good = 1; end
            else slip = 1'b1;
          end else if (m_st == M_VERIFY) begin
            if (ok) begin
              m_good++;
              if (m_good >= LOCK_CNT) begin m_st = M_LOCKED; m_win = 0; m_bad = 0; end
            end else begin m_st = M_SEARCH; m_good = 0; slip = 1'b1; end
          end else begin
            m_win++;
            if (!ok) m_bad++;
            if (m_bad >= BAD_LIMIT) begin
              m_st = M_SEARCH; m_good = 0; m_win = 0; m_bad = 0; slip = 1'b1;
            end else if (m_win >= WINDOW) begin
              m_win = 0; m_bad = 0;
            end
          end
          if (ok && m_st == M_LOCKED) begin
            mdl_ev.push_back($sformatf("%0d blk %h ctrl=%0b", stamp, d, h == 2'b01));
            m_last_data = d;
          end
          if (slip) begin
            m_skip = 1'b1;
            mdl_ev.push_back($sformatf("%0d slip", stamp));
          end
        end
      end
    end
    m_lock = (m_st == M_LOCKED);
    if (m_lock != lock_before) mdl_ev.push_back($sformatf("%0d lock=%0b", stamp, m_lock));
  endtask

  // One clock: drive at negedge, advance model, observe DUT at next negedge.
  task automatic step(input bit b, input bit v, input bit lr);
    bit_in = b; bit_valid = v; lane_rst = lr;
    model_edge(b, v, lr, cyc + 1);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (block_valid) begin
      dut_ev.push_back($sformatf("%0d blk %h ctrl=%0b", cyc, block_data, block_is_ctrl));
      dut_nvalid++; dut_last_data = block_data; dut_last_ctrl = block_is_ctrl;
      $display("block @%0d data=%h ctrl=%0b lock=%0b", cyc, block_data, block_is_ctrl, block_lock);
    end
    if (slip_pulse) begin
      dut_ev.push_back($sformatf("%0d slip", cyc));
      dut_nslip++;
    end
    if (block_lock !== dut_lock_prev) begin
      dut_ev.push_back($sformatf("%0d lock=%0b", cyc, block_lock));
      if (block_lock === 1'b1) lock_rise_cyc = cyc;
      dut_lock_prev = block_lock;
    end
  endtask

  task automatic send_block(input bit [1:0] hdr, input logic [63:0] pl, input bit gap);
    bit [65:0] b = {pl, hdr};
    for (int i = 0; i < 66; i++) begin
      step(b[i], 1'b1, 1'b0);
      if (gap) step(1'($urandom), 1'b0, 1'b0);
    end
  endtask

  task automatic clear_logs();
    dut_ev.delete(); mdl_ev.delete();
    dut_nvalid = 0; dut_nslip = 0; lock_rise_cyc = -1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic test_reset();
    bit_valid = 1'b1;
    repeat (4) begin bit_in = 1'($urandom); @(negedge clk); end
    checks++;
    if ({block_valid, block_is_ctrl, block_lock, slip_pulse} !== 4'b0) begin
      errors++; $display("FAIL reset_flags got %b expected 0000", {block_valid, block_is_ctrl, block_lock, slip_pulse});
    end
    checks++;
    if (block_data !== 64'd0) begin errors++; $display("FAIL reset_data got %h expected 0", block_data); end
    bit_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_aligned();
    int s;
    clear_logs(); s = cyc;
    repeat (8) send_block(2'b10, PAT, 1'b0);
    checks++;
    if (lock_rise_cyc != s + 264) begin errors++; $display("FAIL aligned_lock_cycle got %0d expected %0d", lock_rise_cyc, s + 264); end
    checks++;
    if (dut_nvalid != 5) begin errors++; $display("FAIL aligned_valid_count got %0d expected 5", dut_nvalid); end
    checks++;
    if (dut_last_data !== PAT || dut_last_ctrl !== 1'b0) begin
      errors++; $display("FAIL aligned_payload got %h/%b expected %h/0", dut_last_data, dut_last_ctrl, PAT);
    end
    checks++;
    if (dut_ev.size() != mdl_ev.size()) begin errors++; $display("FAIL aligned_log_len got %0d expected %0d", dut_ev.size(), mdl_ev.size()); end
    checks++;
    for (int i = 0; i < dut_ev.size() && i < mdl_ev.size(); i++)
      if (dut_ev[i] != mdl_ev[i]) begin errors++; $display("FAIL aligned_log[%0d] got '%s' expected '%s'", i, dut_ev[i], mdl_ev[i]); break; end
  endtask

  task automatic test_offset();
    int s;
    step(1'($urandom), 1'b1, 1'b1);
    clear_logs(); s = cyc;
    repeat (3) step(1'b0, 1'b1, 1'b0);
    // Payload bits 63:62 forced low so every misaligned window sees an invalid header.
    repeat (8) send_block(2'b10, rnd64() & 64'h3FFF_FFFF_FFFF_FFFF, 1'b0);
    checks++;
    if (dut_nslip != 3) begin errors++; $display("FAIL offset_slips got %0d expected 3", dut_nslip); end
    checks++;
    if (lock_rise_cyc != s + 465) begin errors++; $display("FAIL offset_lock_cycle got %0d expected %0d", lock_rise_cyc, s + 465); end
    checks++;
    if (dut_ev.size() != mdl_ev.size()) begin errors++; $display("FAIL offset_log_len got %0d expected %0d", dut_ev.size(), mdl_ev.size()); end
    checks++;
    for (int i = 0; i < dut_ev.size() && i < mdl_ev.size(); i++)
      if (dut_ev[i] != mdl_ev[i]) begin errors++; $display("FAIL offset_log[%0d] got '%s' expected '%s'", i, dut_ev[i], mdl_ev[i]); break; end
  endtask

  task automatic test_bad_window();
    bit b;
    step(1'($urandom), 1'b1, 1'b1);
    clear_logs();
    repeat (4) send_block(2'b10, rnd64(), 1'b0);
    for (int k = 0; k < 16; k++) begin
      b = 1'($urandom);
      if (k % 8 == 3) send_block({b, b}, rnd64(), 1'b0);
      else send_block(2'b10, rnd64(), 1'b0);
    end
    checks++;
    if (block_lock !== 1'b1) begin errors++; $display("FAIL bad_single_lock got %b expected 1", block_lock); end
    checks++;
    if (dut_nvalid != 15) begin errors++; $display("FAIL bad_single_valid got %0d expected 15", dut_nvalid); end
    send_block(2'b00, rnd64(), 1'b0);
    send_block(2'b01, rnd64(), 1'b0);
    send_block(2'b11, rnd64(), 1'b0);
    checks++;
    if (block_lock !== 1'b0 || slip_pulse !== 1'b1) begin
      errors++; $display("FAIL bad_double_drop got lock=%b slip=%b expected lock=0 slip=1", block_lock, slip_pulse);
    end
    checks++;
    if (dut_nslip != 1 || dut_nvalid != 16) begin
      errors++; $display("FAIL bad_double_counts got slips=%0d valid=%0d expected 1/16", dut_nslip, dut_nvalid);
    end
    checks++;
    if (dut_ev.size() != mdl_ev.size()) begin errors++; $display("FAIL bad_log_len got %0d expected %0d", dut_ev.size(), mdl_ev.size()); end
    checks++;
    for (int i = 0; i < dut_ev.size() && i < mdl_ev.size(); i++)
      if (dut_ev[i] != mdl_ev[i]) begin errors++; $display("FAIL bad_log[%0d] got '%s' expected '%s'", i, dut_ev[i], mdl_ev[i]); break; end
  endtask

  task automatic test_ctrl();
    step(1'($urandom), 1'b1, 1'b1);
    clear_logs();
    repeat (4) send_block(2'b10, rnd64(), 1'b0);
    send_block(2'b01, CPAT, 1'b0);
    checks++;
    if (dut_last_ctrl !== 1'b1 || dut_last_data !== CPAT) begin
      errors++; $display("FAIL ctrl_block got %h/%b expected %h/1", dut_last_data, dut_last_ctrl, CPAT);
    end
    repeat (6) send_block(($urandom & 1) ? 2'b01 : 2'b10, rnd64(), 1'b0);
    checks++;
    if (dut_nvalid != 8) begin errors++; $display("FAIL ctrl_valid_count got %0d expected 8", dut_nvalid); end
    checks++;
    if (dut_ev.size() != mdl_ev.size()) begin errors++; $display("FAIL ctrl_log_len got %0d expected %0d", dut_ev.size(), mdl_ev.size()); end
    checks++;
    for (int i = 0; i < dut_ev.size() && i < mdl_ev.size(); i++)
      if (dut_ev[i] != mdl_ev[i]) begin errors++; $display("FAIL ctrl_log[%0d] got '%s' expected '%s'", i, dut_ev[i], mdl_ev[i]); break; end
  endtask

  task automatic test_gap_lane_rst();
    int s;
    step(1'($urandom), 1'b1, 1'b1);
    clear_logs(); s = cyc;
    repeat (5) send_block(2'b10, rnd64(), 1'b1);
    checks++;
    if (lock_rise_cyc != s + 527) begin errors++; $display("FAIL gap_lock_cycle got %0d expected %0d", lock_rise_cyc, s + 527); end
    checks++;
    if (dut_nvalid != 2) begin errors++; $display("FAIL gap_valid_count got %0d expected 2", dut_nvalid); end
    repeat (30) step(1'($urandom), 1'b1, 1'b0);
    step(1'($urandom), 1'b1, 1'b1);
    checks++;
    if (block_lock !== 1'b0 || block_data !== m_last_data) begin
      errors++; $display("FAIL lane_rst_effect got lock=%b data=%h expected lock=0 data=%h", block_lock, block_data, m_last_data);
    end
    repeat (3) send_block(2'b10, rnd64(), 1'b0);
    checks++;
    if (block_lock !== 1'b0 || dut_nvalid != 2) begin
      errors++; $display("FAIL lane_rst_early got lock=%b valid=%0d expected 0/2", block_lock, dut_nvalid);
    end
    send_block(2'b10, rnd64(), 1'b0);
    checks++;
    if (block_lock !== 1'b1 || dut_nvalid != 3) begin
      errors++; $display("FAIL lane_rst_relock got lock=%b valid=%0d expected 1/3", block_lock, dut_nvalid);
    end
    checks++;
    if (dut_ev.size() != mdl_ev.size()) begin errors++; $display("FAIL gap_log_len got %0d expected %0d", dut_ev.size(), mdl_ev.size()); end
    checks++;
    for (int i = 0; i < dut_ev.size() && i < mdl_ev.size(); i++)
      if (dut_ev[i] != mdl_ev[i]) begin errors++; $display("FAIL gap_log[%0d] got '%s' expected '%s'", i, dut_ev[i], mdl_ev[i]); break; end
  endtask

  task automatic test_async_rst();
    repeat (20) step(1'($urandom), 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    checks++;
    if ({block_valid, block_is_ctrl, block_lock, slip_pulse} !== 4'b0 || block_data !== 64'd0) begin
      errors++; $display("FAIL async_rst got flags=%b data=%h expected 0000/0", {block_valid, block_is_ctrl, block_lock, slip_pulse}, block_data);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0; bit_valid = 1'b0;
    model_clear(); m_lock = 1'b0; dut_lock_prev = 1'b0;
    clear_logs();
    repeat (3) send_block(2'b10, rnd64(), 1'b0);
    checks++;
    if (dut_nvalid != 0 || block_lock !== 1'b0) begin
      errors++; $display("FAIL async_rst_early got valid=%0d lock=%b expected 0/0", dut_nvalid, block_lock);
    end
    send_block(2'b10, rnd64(), 1'b0);
    checks++;
    if (dut_nvalid != 1 || block_lock !== 1'b1) begin
      errors++; $display("FAIL async_rst_relock got valid=%0d lock=%b expected 1/1", dut_nvalid, block_lock);
    end
    checks++;
    if (dut_ev.size() != mdl_ev.size()) begin errors++; $display("FAIL rst_log_len got %0d expected %0d", dut_ev.size(), mdl_ev.size()); end
    checks++;
    for (int i = 0; i < dut_ev.size() && i < mdl_ev.size(); i++)
      if (dut_ev[i] != mdl_ev[i]) begin errors++; $display("FAIL rst_log[%0d] got '%s' expected '%s'", i, dut_ev[i], mdl_ev[i]); break; end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_aligned();
    test_offset();
    test_bad_window();
    test_ctrl();
    test_gap_lane_rst();
    test_async_rst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/usb4_block_aligner.md
Name: usb4_block_aligner

Overview:
Sits directly downstream of the receive-lane descrambler. Consumes its serial descrambled bit stream, assembles 66-bit blocks (2-bit sync header plus 64-bit payload), and acquires and maintains block lock using a header-validity state machine with bit-slip. Emits 64-bit payload words tagged data/control to the receive logical-layer framing stage.

Parameters:
LOCK_CNT, 64, consecutive valid headers required to declare lock (range 2..255)
WINDOW, 64, number of blocks in the lock-loss monitoring window (range 2..255)
BAD_LIMIT, 16, invalid headers within one window that force loss of lock (range 1..WINDOW)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
bit_in  in  1  descrambled serial bit
bit_valid  in  1  bit_in is valid this cycle (descrambler enable)
lane_rst  in  1  synchronous realign request (pulsed alongside descrambler seed reload)
block_data  out  64  payload; block bit 2 maps to block_data[0]
block_is_ctrl  out  1  1 = control block (header 2'b01), 0 = data block (header 2'b10)
block_valid  out  1  one-cycle strobe qualifying block_data and block_is_ctrl
block_lock  out  1  high while in the LOCKED state
slip_pulse  out  1  one-cycle strobe when a bit-slip is taken

Behaviour:
- Reset (rst=1): state=SEARCH; bit_cnt=0; good_cnt=0; win_cnt=0; bad_cnt=0. All outputs 0, including block_data.
- Bit order: the first accepted bit of a block is blk[0]. hdr={blk[1],blk[0]}. 2'b10 (first bit 0, second 1) = data. 2'b01 = control. 2'b00 and 2'b11 are invalid.
- Bit accept: on each clk with bit_valid=1, bit_in shifts into the collector and bit_cnt increments (0..65). On the bit that makes bit_cnt=65, the block is complete and is evaluated at that edge; bit_cnt wraps to 0.
- Cycles with bit_valid=0 change nothing.
- Slip: when a slip is taken, the next accepted bit_valid bit is discarded (not stored, bit_cnt not advanced). This shifts the boundary by one bit. slip_pulse is asserted for one cycle, in the cycle after evaluation.
- State machine (evaluated once per completed block):
  - SEARCH: valid hdr -> VERIFY, good_cnt=1. Invalid hdr -> stay in SEARCH, slip.
  - VERIFY: valid hdr -> good_cnt+1; when good_cnt reaches LOCK_CNT -> LOCKED, clear win_cnt and bad_cnt. Invalid hdr -> SEARCH, good_cnt=0, slip.
  - LOCKED: win_cnt+1 per block; invalid hdr -> bad_cnt+1.
    - If bad_cnt reaches BAD_LIMIT -> SEARCH, clear counters, slip. This check takes priority over window completion in the same block.
    - Else if win_cnt reaches WINDOW -> clear win_cnt and bad_cnt, stay LOCKED.
- Output: block_valid=1 for exactly one cycle, in the cycle after the edge that evaluated a valid-header block, when the post-evaluation state is LOCKED. The block that completes lock is emitted.
  - Invalid-header blocks are never emitted.
  - block_data and block_is_ctrl hold their last values between strobes.
- block_lock is registered and changes in the same cycle as the state register (latency 1 after the evaluating edge).
- lane_rst=1: synchronous return to the reset values, except block_data, which is held. lane_rst has priority over bit_valid in the same cycle. Any partial block is discarded, and a pending slip is cancelled.
- rst asserted mid-block: immediate clear, no output strobe.
- Counter widths: 8 bits, saturation not needed given the parameter ranges. bit_cnt is 7 bits.

Decomposition:
- Package usb4_pcs_pkg holds:
  - BLOCK_W=66
  - PAYLOAD_W=64
  - HDR_DATA=2'b10
  - HDR_CTRL=2'b01
  - aligner state enum {SEARCH, VERIFY, LOCKED}
- Sub-module usb4_block_collector: 66-bit shift register, bit counter, slip-discard flag. Outputs blk_done and blk[65:0].
- Top level: the lock state machine and output registers.

Test Plan:
Use LOCK_CNT=4, WINDOW=8, BAD_LIMIT=2 unless stated.
- Aligned stream of data blocks, payload 64'h0123_4567_89AB_CDEF, continuous bit_valid -> block_lock rises 1 cycle after the 4th block's last bit; block_valid pulses once for that block and for each subsequent block, with block_is_ctrl=0 and the payload matching.
- Stream offset by 3 bits -> exactly 3 slip_pulse strobes (each followed by one discarded bit) before the first VERIFY; lock is reached after 4 further good blocks.
- While locked, inject 1 bad header in each 8-block window -> lock is held, and bad blocks produce no block_valid. Inject 2 bad headers in one window -> block_lock=0 one cycle after the 2nd bad block, plus one slip_pulse.
- Control block (header 2'b01, payload 64'hFFFF_0000_FFFF_0000) while locked -> block_valid with block_is_ctrl=1 and block_data matching.
- bit_valid toggling 1/0 every cycle -> same results as the continuous case, at half rate. lane_rst pulse mid-block -> block_lock=0 and partial bits discarded; reacquisition takes 4 blocks.
- rst asserted while LOCKED mid-block -> all outputs 0 immediately. After release, no block_valid appears before 4 valid blocks.
